param_sync_tracker: RTL and testbench

PARAM_SYNC_TRACKER -- requirements
Module: param_sync_tracker

---
 rtl/param_sync_pkg.sv | 20 ++
 rtl/param_stabilizer.sv | 42 ++++
 rtl/param_sync_tracker.sv | 94 +++++++++
 tb/tb_param_sync_tracker.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/param_sync_pkg.sv
// Shared defaults and channel naming for the parameter synchroniser/tracker.
package param_sync_pkg;
  localparam int N_CH_DEFAULT  = 12;
  localparam int WIDTH_DEFAULT = 10;

  typedef enum logic [3:0] {
    VOLUME           = 4'd0,
    PITCH            = 4'd1,
    DELAY_WET        = 4'd2,
    DELAY_RATE       = 4'd3,
    DELAY_FEEDBACK   = 4'd4,
    REVERB_WET       = 4'd5,
    REVERB_SIZE      = 4'd6,
    REVERB_FEEDBACK  = 4'd7,
    FILTER_QUALITY   = 4'd8,
    FILTER_CUTOFF    = 4'd9,
    DISTORTION_DRIVE = 4'd10,
    CRUSH_PRESSURE   = 4'd11
  } channel_e;
endpackage

// File: rtl/param_stabilizer.sv
// One channel: multi-flop synchroniser, candidate register and stability counter.
// accept is asserted when the candidate has been stable long enough and is new.
module param_stabilizer
  import param_sync_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEFAULT,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk_pixel,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] accepted,
  output logic [WIDTH-1:0] cand,
  output logic             accept
);
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      cand <= '0;
      cnt  <= '0;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      // Synchronised word -> candidate; any difference restarts the stability count
      if (sync_q[SYNC_STAGES-1] != cand) begin
        cand <= sync_q[SYNC_STAGES-1];
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign accept = (cnt == CNT_MAX) && (cand != accepted);
endmodule

// File: rtl/param_sync_tracker.sv
// Synchronises N_CH parameter words from a foreign domain, publishes tear-free values
// and reports each changed channel once through a round-robin valid/ready event slot.
module param_sync_tracker
  import param_sync_pkg::*;
#(
  parameter int N_CH          = N_CH_DEFAULT,
  parameter int WIDTH         = WIDTH_DEFAULT,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                      clk_pixel,
  input  logic                      rst_n,
  input  logic [N_CH*WIDTH-1:0]     params_async_in,
  output logic [N_CH*WIDTH-1:0]     params_out,
  output logic                      change_valid,
  input  logic                      change_ready,
  output logic [$clog2(N_CH)-1:0]   change_ch,
  output logic [WIDTH-1:0]          change_value,
  output logic [N_CH-1:0]           pending_mask
);
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]  accept;
  logic [WIDTH-1:0] cand [N_CH];
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  clr;
  logic [CH_W-1:0]  ptr;
  logic [CH_W-1:0]  sel;
  logic             found;
  logic             load;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    param_stabilizer #(
      .WIDTH         (WIDTH),
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stab (
      .clk_pixel (clk_pixel),
      .rst_n     (rst_n),
      .din       (params_async_in[c*WIDTH +: WIDTH]),
      .accepted  (params_out[c*WIDTH +: WIDTH]),
      .cand      (cand[c]),
      .accept    (accept[c])
    );
  end

  // Round-robin search starting just after the last granted channel
  always_comb begin
    int idx;
    idx   = 0;
    sel   = ptr;
    found = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = (int'(ptr) + i) % N_CH;
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = CH_W'(idx);
      end
    end
  end

  assign load         = (!change_valid || change_ready) && found;
  assign clr          = load ? (N_CH'(1) << sel) : '0;
  assign pending_mask = pending;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      params_out <= '0;
      pending    <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++)
        if (accept[c]) params_out[c*WIDTH +: WIDTH] <= cand[c];
      // A fresh accept on the grant edge keeps the channel pending
      pending <= (pending & ~clr) | accept;
    end
  end

  // Event slot: refills whenever empty or being consumed
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      change_valid <= 1'b0;
      change_ch    <= '0;
      change_value <= '0;
      ptr          <= CH_W'(N_CH - 1);
    end else if (!change_valid || change_ready) begin
      change_valid <= found;
      if (found) begin
        change_ch    <= sel;
        change_value <= params_out[sel*WIDTH +: WIDTH];
        ptr          <= sel;
      end
    end
  end
endmodule

// File: tb/tb_param_sync_tracker.sv
// Directed bench for param_sync_tracker with default parameters.
module tb_param_sync_tracker;
  logic         clk_pixel = 1'b0;
  logic         rst_n;
  logic [119:0] params_async_in;
  logic [119:0] params_out;
  logic         change_valid;
  logic         change_ready;
  logic [3:0]   change_ch;
  logic [9:0]   change_value;
  logic [11:0]  pending_mask;

  int nvec = 0;
  int nerr = 0;

  param_sync_tracker dut (
    .clk_pixel       (clk_pixel),
    .rst_n           (rst_n),
    .params_async_in (params_async_in),
    .params_out      (params_out),
    .change_valid    (change_valid),
    .change_ready    (change_ready),
    .change_ch       (change_ch),
    .change_value    (change_value),
    .pending_mask    (pending_mask)
  );

  always #5 clk_pixel = ~clk_pixel;

  function automatic logic [9:0] po(input int c);
    return params_out[c*10 +: 10];
  endfunction

  task automatic reset_dut();
    rst_n = 1'b0;
    params_async_in = '0;
    change_ready = 1'b1;
    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    nvec++; if (params_out !== 120'd0) begin nerr++; $display("FAIL reset_params_out got %h want 0", params_out); end
    nvec++; if (change_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", change_valid); end
    nvec++; if (change_ch !== 4'd0) begin nerr++; $display("FAIL reset_ch got %0d want 0", change_ch); end
    nvec++; if (change_value !== 10'd0) begin nerr++; $display("FAIL reset_value got %h want 0", change_value); end
    nvec++; if (pending_mask !== 12'd0) begin nerr++; $display("FAIL reset_pending got %h want 0", pending_mask); end
  endtask

  task automatic test_latency();
    change_ready = 1'b1;
    @(negedge clk_pixel);
    params_async_in[9:0] = 10'h155;
    repeat (6) @(posedge clk_pixel);
    #1;
    nvec++; if (po(0) !== 10'h000) begin nerr++; $display("FAIL latency_early got %h want 000", po(0)); end
    @(posedge clk_pixel); #1;
    nvec++; if (po(0) !== 10'h155) begin nerr++; $display("FAIL latency_edge7 got %h want 155", po(0)); end
    nvec++; if (pending_mask !== 12'h001) begin nerr++; $display("FAIL latency_pending got %h want 001", pending_mask); end
    @(posedge clk_pixel); #1;
    nvec++; if (change_valid !== 1'b1 || change_ch !== 4'd0 || change_value !== 10'h155)
      begin nerr++; $display("FAIL latency_event got v=%b ch=%0d val=%h want v=1 ch=0 val=155", change_valid, change_ch, change_value); end
    nvec++; if (pending_mask !== 12'h000) begin nerr++; $display("FAIL latency_pending_clr got %h want 000", pending_mask); end
    @(posedge clk_pixel); #1;
    nvec++; if (change_valid !== 1'b0) begin nerr++; $display("FAIL latency_single_event got %b want 0", change_valid); end
  endtask

  task automatic test_glitch();
    int saw_valid;
    logic [119:0] exp_po;
    saw_valid = 0;
    exp_po = '0;
    exp_po[9:0] = 10'h155;
    @(negedge clk_pixel);
    params_async_in[39:30] = 10'h3FF;
    repeat (2) @(negedge clk_pixel);
    params_async_in[39:30] = 10'h000;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk_pixel); #1;
      if (change_valid === 1'b1) saw_valid++;
    end
    nvec++; if (saw_valid != 0) begin nerr++; $display("FAIL glitch_event got %0d events want 0", saw_valid); end
    nvec++; if (params_out !== exp_po) begin nerr++; $display("FAIL glitch_params_out got %h want %h", params_out, exp_po); end
    nvec++; if (pending_mask !== 12'h000) begin nerr++; $display("FAIL glitch_pending got %h want 000", pending_mask); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] v;
    reset_dut();
    change_ready = 1'b1;
    @(negedge clk_pixel);
    for (int c = 0; c < 12; c++) params_async_in[c*10 +: 10] = 10'h200 + 10'(c * 17);
    repeat (7) @(posedge clk_pixel);
    #1;
    nvec++; if (pending_mask !== 12'hFFF) begin nerr++; $display("FAIL b2b_pending got %h want fff", pending_mask); end
    for (int k = 0; k < 12; k++) begin
      @(posedge clk_pixel); #1;
      v = 10'h200 + 10'(k * 17);
      nvec++;
      if (change_valid !== 1'b1 || change_ch !== 4'(k) || change_value !== v) begin
        nerr++;
        $display("FAIL b2b_event%0d got v=%b ch=%0d val=%h want v=1 ch=%0d val=%h", k, change_valid, change_ch, change_value, k, v);
      end
    end
    @(posedge clk_pixel); #1;
    nvec++; if (change_valid !== 1'b0) begin nerr++; $display("FAIL b2b_drain got %b want 0", change_valid); end
  endtask

  task automatic test_stall();
    int bad;
    bad = 0;
    change_ready = 1'b0;
    @(negedge clk_pixel);
    params_async_in[19:10] = 10'h0AA;
    params_async_in[59:50] = 10'h010;
    repeat (8) @(posedge clk_pixel);
    #1;
    nvec++; if (change_valid !== 1'b1 || change_ch !== 4'd1 || change_value !== 10'h0AA)
      begin nerr++; $display("FAIL stall_first got v=%b ch=%0d val=%h want v=1 ch=1 val=0aa", change_valid, change_ch, change_value); end
    nvec++; if (pending_mask !== 12'h020) begin nerr++; $display("FAIL stall_pending got %h want 020", pending_mask); end
    @(negedge clk_pixel);
    params_async_in[59:50] = 10'h020;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_pixel); #1;
      if (change_valid !== 1'b1 || change_ch !== 4'd1 || change_value !== 10'h0AA) bad++;
    end
    nvec++; if (bad != 0) begin nerr++; $display("FAIL stall_hold got %0d unstable cycles want 0", bad); end
    nvec++; if (po(5) !== 10'h020) begin nerr++; $display("FAIL stall_po5 got %h want 020", po(5)); end
    nvec++; if (pending_mask !== 12'h020) begin nerr++; $display("FAIL stall_coalesce_pending got %h want 020", pending_mask); end
    @(negedge clk_pixel);
    change_ready = 1'b1;
    @(posedge clk_pixel); #1;
    nvec++; if (change_valid !== 1'b1 || change_ch !== 4'd5 || change_value !== 10'h020)
      begin nerr++; $display("FAIL stall_ch5 got v=%b ch=%0d val=%h want v=1 ch=5 val=020", change_valid, change_ch, change_value); end
    @(posedge clk_pixel); #1;
    nvec++; if (change_valid !== 1'b0 || pending_mask !== 12'h000)
      begin nerr++; $display("FAIL stall_single got v=%b pend=%h want v=0 pend=000", change_valid, pending_mask); end
  endtask

  task automatic test_reset_midflight();
    int seen;
    int saw_valid;
    seen = 0;
    saw_valid = 0;
    change_ready = 1'b0;
    @(negedge clk_pixel);
    params_async_in[29:20] = 10'h123;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(posedge clk_pixel); #1;
      if (change_valid === 1'b1) seen = 1;
    end
    nvec++; if (seen == 0) begin nerr++; $display("FAIL midflight_wait got no event within 20 cycles want event"); end
    @(posedge clk_pixel); #2;
    rst_n = 1'b0;
    params_async_in = '0;
    #1;
    nvec++; if (params_out !== 120'd0 || change_valid !== 1'b0 || change_ch !== 4'd0 ||
                change_value !== 10'd0 || pending_mask !== 12'd0) begin
      nerr++;
      $display("FAIL midflight_async_clear got po=%h v=%b ch=%0d val=%h pend=%h want all 0",
               params_out, change_valid, change_ch, change_value, pending_mask);
    end
    @(negedge clk_pixel);
    rst_n = 1'b1;
    change_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk_pixel); #1;
      if (change_valid === 1'b1) saw_valid++;
    end
    nvec++; if (saw_valid != 0) begin nerr++; $display("FAIL midflight_replay got %0d events want 0", saw_valid); end
    nvec++; if (params_out !== 120'd0 || pending_mask !== 12'd0)
      begin nerr++; $display("FAIL midflight_after got po=%h pend=%h want 0", params_out, pending_mask); end
  endtask

  initial begin
    rst_n = 1'b0;
    params_async_in = '0;
    change_ready = 1'b1;
    test_reset();
    test_latency();
    test_glitch();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
